reload_timer: RTL and testbench

Parametrised auto-reload counter/timer, the successor to the team's basic load-on-carry counter. Adds up/down counting, count enable, periodic or one-shot mode, and start/stop control. Also adds a double-buffered reload register and a direct synchronous load. Used as a programmable period generator or tick source for lab datapaths.

---
 rtl/reload_timer.sv | 133 +++++++++++++
 tb/tb_reload_timer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/reload_timer.sv
// reload_timer: auto-reload counter/timer with up/down counting, count enable,
// periodic or one-shot mode, start/stop control, a double-buffered reload
// (shadow) register and a direct synchronous load.
// Optional build macro: RELOAD_TIMER_PRESCALE_EN adds a prescaler so that the
// counter only advances once every PRESCALE enabled RUN cycles.
module reload_timer #(
   parameter int N        = 9,
   parameter int PRESCALE = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         dir,
   input  logic         mode,
   input  logic         start,
   input  logic         stop,
   input  logic         ld,
   input  logic [N-1:0] ld_val,
   input  logic         rld_we,
   input  logic [N-1:0] rld_val,
   output logic [N-1:0] cnt_out,
   output logic         cnt_cout,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [N-1:0] ALL_ONES = '1;

   state_t       state;
   state_t       state_nxt;
   logic [N-1:0] shadow;
   logic [N-1:0] cnt_nxt;
   logic         term;
   logic         tick;
   logic         adv;

   // Terminal value depends on the direction currently requested, so a
   // mid-run direction change is honoured at the very next enabled tick.
   assign term = dir ? (cnt_out == '0) : (cnt_out == ALL_ONES);

`ifdef RELOAD_TIMER_PRESCALE_EN
   localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   logic [PW-1:0] pre;

   // Prescaler: counts enabled RUN cycles, restarts on any control event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pre <= '0;
      else if (ld || stop || start)
         pre <= '0;
      else if (state == RUN && en)
         pre <= (pre == PMAX) ? '0 : pre + 1'b1;
   end

   assign tick = (pre == PMAX);
`else
   // Without the prescaler every enabled RUN cycle is a tick (PRESCALE >= 1).
   assign tick = (PRESCALE >= 1);
`endif

   assign adv      = (state == RUN) && en && tick;
   assign cnt_cout = adv && term;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state: stop wins over everything but ld's counter write; ld freezes
   // the state unless stop is also present.
   always_comb begin
      state_nxt = state;
      if (stop)
         state_nxt = IDLE;
      else if (ld)
         state_nxt = state;
      else if (start)
         state_nxt = RUN;
      else if (adv && term && mode)
         state_nxt = DONE;
   end

   // State decode outputs.
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Next count value following the ld > stop > start > count priority.
   always_comb begin
      cnt_nxt = cnt_out;
      if (ld)
         cnt_nxt = ld_val;
      else if (!stop) begin
         if (start)
            cnt_nxt = shadow;
         else if (adv) begin
            if (!term)
               cnt_nxt = dir ? cnt_out - 1'b1 : cnt_out + 1'b1;
            else if (!mode)
               cnt_nxt = shadow;
         end
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_out <= '0;
      else
         cnt_out <= cnt_nxt;
   end

   // Shadow reload register; a reload in the write cycle still sees the old value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         shadow <= '0;
      else if (rld_we)
         shadow <= rld_val;
   end

endmodule

// File: tb/tb_reload_timer.sv
// Testbench for reload_timer: a behavioural model checked every cycle plus
// directed vectors with hand-computed literal expectations.
module tb_reload_timer;

   localparam int N        = 9;
   localparam int PRESCALE = 4;
   localparam int MODV     = 1 << N;

   logic         clk = 1'b0;
   logic         rst;
   logic         en, dir, mode, start, stop, ld, rld_we;
   logic [N-1:0] ld_val, rld_val;
   logic [N-1:0] cnt_out;
   logic         cnt_cout, busy, done;

   reload_timer #(.N(N), .PRESCALE(PRESCALE)) dut (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode),
      .start(start), .stop(stop), .ld(ld), .ld_val(ld_val),
      .rld_we(rld_we), .rld_val(rld_val), .cnt_out(cnt_out),
      .cnt_cout(cnt_cout), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model: count value, reload value, phase (0 idle, 1 run, 2 done)
   // and number of enabled run cycles seen since the last control event.
   int m_cnt   = 0;
   int m_sh    = 0;
   int m_phase = 0;
   int m_runs  = 0;

   function automatic bit m_tick();
`ifdef RELOAD_TIMER_PRESCALE_EN
      return (m_runs % PRESCALE) == PRESCALE - 1;
`else
      return 1'b1;
`endif
   endfunction

   function automatic bit m_term();
      return dir ? (m_cnt == 0) : (m_cnt == MODV - 1);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt = 0; m_sh = 0; m_phase = 0; m_runs = 0;
      end else begin
         int  old_sh;
         bit  fire, at_end;
         old_sh = m_sh;
         fire   = (m_phase == 1) && en && m_tick();
         at_end = m_term();
         if (ld)
            m_cnt = ld_val;
         else if (stop)
            m_cnt = m_cnt;
         else if (start)
            m_cnt = old_sh;
         else if (fire) begin
            if (!at_end)
               m_cnt = dir ? (m_cnt + MODV - 1) % MODV : (m_cnt + 1) % MODV;
            else if (!mode)
               m_cnt = old_sh;
         end
         if (stop)
            m_phase = 0;
         else if (!ld && start)
            m_phase = 1;
         else if (!ld && fire && at_end && mode)
            m_phase = 2;
         if (ld || stop || start)
            m_runs = 0;
         else if (m_phase_was_run(fire, en))
            m_runs = m_runs + 1;
         if (rld_we)
            m_sh = rld_val;
      end
   end

   // True when the pre-edge phase was RUN with en high (fire implies it too).
   function automatic bit m_phase_was_run(input bit f, input logic e);
      return f || (e && m_phase_prev == 1);
   endfunction

   int m_phase_prev = 0;
   always @(negedge clk) m_phase_prev = m_phase;

   // Literal expectations posted by the stimulus, checked at the next negedge.
   int lit_id   = 0;
   int lit_seen = 0;
   int lit_cnt;
   bit lit_busy, lit_done, lit_cout;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model cnt_out", int'(cnt_out), m_cnt);
      chk("model busy", int'(busy), int'(m_phase == 1));
      chk("model done", int'(done), int'(m_phase == 2));
      chk("model cnt_cout", int'(cnt_cout),
          int'(!rst && m_phase == 1 && en && m_term() && m_tick()));
      if (lit_id != lit_seen) begin
         lit_seen = lit_id;
         chk("lit cnt_out", int'(cnt_out), lit_cnt);
         chk("lit busy", int'(busy), int'(lit_busy));
         chk("lit done", int'(done), int'(lit_done));
         chk("lit cnt_cout", int'(cnt_cout), int'(lit_cout));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pin(input int c, input bit b, input bit d, input bit co);
      lit_cnt  = c;
      lit_busy = b;
      lit_done = d;
      lit_cout = co;
      lit_id++;
   endtask

   task automatic write_shadow(input int v);
      rld_we = 1'b1; rld_val = N'(v);
      cyc(1);
      rld_we = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      en = 0; dir = 0; mode = 0; start = 0; stop = 0; ld = 0; rld_we = 0;
      ld_val = '0; rld_val = '0;
      cyc(2);
      pin(0, 0, 0, 0);
      cyc(1);
      rst = 1'b0;
      cyc(1);

`ifdef RELOAD_TIMER_PRESCALE_EN
      // Prescaled up periodic run from 510.
      write_shadow(510);
      en = 1; dir = 0; mode = 0; start = 1;
      cyc(1); start = 0; pin(510, 1, 0, 0);
      cyc(1); pin(510, 1, 0, 0);
      cyc(1); pin(510, 1, 0, 0);
      cyc(1); pin(510, 1, 0, 0);
      cyc(1); pin(511, 1, 0, 0);
      cyc(2); pin(511, 1, 0, 0);
      cyc(1); pin(511, 1, 0, 1);
      cyc(1); pin(510, 1, 0, 0);
      cyc(9);
      stop = 1; cyc(1); stop = 0; pin(int'(cnt_out), 0, 0, 0);
      cyc(3);
`else
      // Up periodic from 508, period 4.
      write_shadow(508);
      en = 1; dir = 0; mode = 0; start = 1;
      cyc(1); start = 0; pin(508, 1, 0, 0);
      cyc(1); pin(509, 1, 0, 0);
      cyc(1); pin(510, 1, 0, 0);
      cyc(1); pin(511, 1, 0, 1);
      cyc(1); pin(508, 1, 0, 0);
      cyc(3); pin(511, 1, 0, 1);

      // Down one-shot from 3.
      stop = 1; cyc(1); stop = 0; pin(511, 0, 0, 0);
      write_shadow(3);
      dir = 1; mode = 1; start = 1;
      cyc(1); start = 0; pin(3, 1, 0, 0);
      cyc(1); pin(2, 1, 0, 0);
      cyc(2); pin(0, 1, 0, 1);
      cyc(1); pin(0, 0, 1, 0);
      cyc(2); pin(0, 0, 1, 0);
      start = 1; cyc(1); start = 0; pin(3, 1, 0, 0);

      // Shadow write coinciding with a reload uses the old value.
      stop = 1; cyc(1); stop = 0;
      write_shadow(509);
      dir = 0; mode = 0; start = 1;
      cyc(1); start = 0; pin(509, 1, 0, 0);
      cyc(2); pin(511, 1, 0, 1);
      rld_we = 1; rld_val = 9'd100;
      cyc(1); rld_we = 0; pin(509, 1, 0, 0);
      cyc(2); pin(511, 1, 0, 1);
      cyc(1); pin(100, 1, 0, 0);

      // ld + stop + start together: load wins the count, stop wins the state.
      ld = 1; ld_val = 9'd42; stop = 1; start = 1;
      cyc(1); ld = 0; stop = 0; start = 0; pin(42, 0, 0, 0);
      cyc(3); pin(42, 0, 0, 0);
      start = 1; cyc(1); start = 0; pin(100, 1, 0, 0);
      ld = 1; ld_val = 9'd7; cyc(1); ld = 0; pin(7, 1, 0, 0);
      cyc(1); pin(8, 1, 0, 0);

      // Down-to-up direction change mid-run.
      dir = 1; cyc(2); pin(6, 1, 0, 0);
      dir = 0; cyc(1); pin(7, 1, 0, 0);

      // Enable hold, then asynchronous reset between edges.
      ld = 1; ld_val = 9'd200; cyc(1); ld = 0; pin(200, 1, 0, 0);
      en = 0; cyc(5); pin(200, 1, 0, 0);
      rst = 1; pin(0, 0, 0, 0);
      cyc(1); rst = 0;
      en = 1; dir = 0; start = 1;
      cyc(1); start = 0; pin(0, 1, 0, 0);
      cyc(1); pin(1, 1, 0, 0);
      cyc(2);
`endif

      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
